// File: rtl/object_buffer.sv
// object_buffer: FWFT FIFO of 128-bit TABLE_ENTRY records between fetch and the encoder
// Ports: clk/reset (sync, active-high); fetch side ob_valid, entry, ob_full, ob_afull;
// flush clears contents; consumer side out_valid, out_entry, out_nested, out_ready;
// out_count is the current occupancy 0..DEPTH.
module object_buffer #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ob_valid,
  input  logic [127:0]             entry,
  output logic                     ob_full,
  output logic                     ob_afull,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [127:0]             out_entry,
  output logic                     out_nested,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   out_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  assign ob_full    = count_q == CW'(DEPTH);
  assign ob_afull   = count_q >= CW'(AFULL_LVL);
  assign out_valid  = count_q != '0;
  assign out_entry  = mem_q[rd_q];
  assign out_nested = out_entry[64];
  assign out_count  = count_q;
  assign push       = ob_valid & ~ob_full & ~flush;
  assign pop        = out_valid & out_ready & ~flush;
  always_comb begin
    wr_d    = flush ? '0 : push ? wr_q + AW'(1) : wr_q;
    rd_d    = flush ? '0 : pop ? rd_q + AW'(1) : rd_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) mem_q[wr_q] <= entry;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_object_buffer.sv
// tb_object_buffer: directed plus random stimulus against a queue reference model
module tb_object_buffer;
  logic         clk = 0;
  logic         reset = 1, ob_valid = 0, flush = 0, out_ready = 0;
  logic [127:0] entry = '0;
  logic         ob_full, ob_afull, out_valid, out_nested;
  logic [127:0] out_entry;
  logic [3:0]   out_count;
  int           vecs = 0, miss = 0;
  logic [127:0] q[$];

  object_buffer #(.DEPTH(8), .AFULL_LVL(6)) dut (
    .clk(clk), .reset(reset), .ob_valid(ob_valid), .entry(entry),
    .ob_full(ob_full), .ob_afull(ob_afull), .flush(flush),
    .out_valid(out_valid), .out_entry(out_entry), .out_nested(out_nested),
    .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check();
    cmp("out_count", 128'(out_count), 128'(q.size()));
    cmp("out_valid", 128'(out_valid), 128'(q.size() != 0));
    cmp("ob_full", 128'(ob_full), 128'(q.size() == 8));
    cmp("ob_afull", 128'(ob_afull), 128'(q.size() >= 6));
    if (q.size() != 0) begin
      cmp("out_entry", out_entry, q[0]);
      cmp("out_nested", 128'(out_nested), 128'(q[0][64]));
    end
  endtask

  task automatic step(input logic v, input logic [127:0] e, input logic r, input logic f, input logic rs);
    logic push_m, pop_m;
    ob_valid = v; entry = e; out_ready = r; flush = f; reset = rs;
    push_m = v && q.size() < 8 && !f;
    pop_m  = q.size() > 0 && r && !f;
    @(posedge clk); #1;
    if (rs || f) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(e);
    end
    check();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0);
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] x;
    step(0, '0, 0, 0, 1);
    cmp("reset_entry", out_entry, '0);
    cmp("reset_nested", 128'(out_nested), '0);
    step(1, 128'h1, 0, 0, 0);
    step(1, {63'h0, 1'b1, 64'hdead}, 0, 0, 0);
    idle();
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 128'(i + 16) | (128'(i[0]) << 64), 0, 0, 0);
    step(1, 128'hbad, 0, 0, 0);
    step(1, 128'hbad, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, '0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, rnd(), 0, 0, 0);
    x = 128'h5a5a;
    step(1, x, 1, 0, 0);
    step(1, x, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, rnd(), 1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, rnd(), 0, 0, 0);
    step(1, 128'hf1, 1, 1, 0);
    cmp("flush_valid", 128'(out_valid), '0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, rnd(), 0, 0, 0);
    step(1, rnd(), 1, 0, 1);
    cmp("midreset_entry", out_entry, '0);
    step(1, 128'hb, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
